// File: rtl/ecc_decode_stage.sv
// ecc_decode_stage: registered, handshaked wrapper around the combinational
// ECC decoder. A request is masked and held on the decoder inputs, the
// decoder result is captured one cycle later into a held output register,
// and saturating counters track corrected and uncorrectable words.
module ecc_decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_codeword,
  input  logic [1:0]            in_width,
  output logic [DATA_WIDTH-1:0] dec_codeword,
  output logic [1:0]            dec_width,
  input  logic [DATA_WIDTH-1:0] dec_data,
  input  logic [1:0]            dec_errors,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_errors,
  input  logic                  cnt_clear,
  output logic [CNT_WIDTH-1:0]  cnt_corrected,
  output logic [CNT_WIDTH-1:0]  cnt_uncorrectable,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] ERR_CLEAN   = 2'd0;
  localparam logic [1:0] ERR_CORR    = 2'd1;
  localparam logic [1:0] ERR_UNCORR  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] cw_p0;
  logic [1:0]            width_p0;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [1:0]            err_p1;
  logic                  vld_p1;
  logic [CNT_WIDTH-1:0]  cnt_corr;
  logic [CNT_WIDTH-1:0]  cnt_uncorr;

  logic                  accept;
  logic                  capture;
  logic                  legal_p0;
  logic [1:0]            err_res;
  logic [DATA_WIDTH-1:0] data_res;

  // Zero every bit at or above the codeword length (8 << code). The reserved
  // code 3 yields a length beyond any legal DATA_WIDTH, so the word passes
  // through untouched; its result is forced to "illegal" anyway.
  function automatic logic [DATA_WIDTH-1:0] mask_codeword(
    input logic [DATA_WIDTH-1:0] cw,
    input logic [1:0]            w
  );
    logic [DATA_WIDTH-1:0] m;
    int                    len;
    len = 8 << w;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      m[i] = (i < len);
    end
    return cw & m;
  endfunction

  // A width code is legal only if its length fits within DATA_WIDTH.
  function automatic logic width_legal(input logic [1:0] w);
    case (w)
      2'd0:    return 1'b1;
      2'd1:    return (DATA_WIDTH >= 16);
      2'd2:    return (DATA_WIDTH >= 32);
      default: return 1'b0;
    endcase
  endfunction

  // Fold the raw decoder status into the reported status: illegal widths
  // override everything, and a decoder "3" on a legal width is uncorrectable.
  function automatic logic [1:0] map_errors(
    input logic [1:0] e,
    input logic       legal
  );
    if (!legal) begin
      return ERR_ILLEGAL;
    end
    if (e == 2'd3) begin
      return ERR_UNCORR;
    end
    return e;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) begin
      return c;
    end
    return c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign accept  = (state == IDLE) && in_valid;
  assign capture = (state == EVAL);

  // State register; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic for IDLE -> EVAL -> HOLD -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EVAL;
      EVAL:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage 0: request capture onto the decoder inputs ----
  // Masked codeword and width are loaded on acceptance and then held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cw_p0    <= '0;
      width_p0 <= 2'd0;
    end else if (accept) begin
      cw_p0    <= mask_codeword(in_codeword, in_width);
      width_p0 <= in_width;
    end
  end

  // The decoder has the whole EVAL cycle to settle on the held inputs.
  assign legal_p0 = width_legal(width_p0);
  assign err_res  = map_errors(dec_errors, legal_p0);
  assign data_res = legal_p0 ? dec_data : '0;

  // ---- stage 1: result capture and output handshake ----
  // Result is captured in EVAL and held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      err_p1  <= ERR_CLEAN;
    end else if (capture) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_res;
      err_p1  <= err_res;
    end else if ((state == HOLD) && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Statistics counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (cnt_clear) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (capture) begin
      if (err_res == ERR_CORR) begin
        cnt_corr <= sat_inc(cnt_corr);
      end
      if (err_res == ERR_UNCORR) begin
        cnt_uncorr <= sat_inc(cnt_uncorr);
      end
    end
  end

  assign in_ready          = (state == IDLE);
  assign busy              = (state != IDLE);
  assign dec_codeword      = cw_p0;
  assign dec_width         = width_p0;
  assign out_valid         = vld_p1;
  assign out_data          = data_p1;
  assign out_errors        = err_p1;
  assign cnt_corrected     = cnt_corr;
  assign cnt_uncorrectable = cnt_uncorr;

endmodule

// File: tb/tb_ecc_decode_stage.sv
// Testbench for ecc_decode_stage. Two instances run in lockstep on shared
// handshake inputs: a 32-bit one with 16-bit counters and a 16-bit one with
// 2-bit counters (for width-range and saturation cases). A small stand-in
// decoder drives each instance: status = number of ones in the low byte
// (3 or more reported as 3), data = codeword shifted right by 8.
module tb_ecc_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clear;
  logic [31:0] in_codeword;
  logic [1:0]  in_width;

  logic        in_ready_a, out_valid_a, busy_a;
  logic [31:0] dec_codeword_a, dec_data_a, out_data_a;
  logic [1:0]  dec_width_a, dec_errors_a, out_errors_a;
  logic [15:0] cnt_corr_a, cnt_unc_a;

  logic        in_ready_b, out_valid_b, busy_b;
  logic [15:0] dec_codeword_b, dec_data_b, out_data_b;
  logic [1:0]  dec_width_b, dec_errors_b, out_errors_b;
  logic [1:0]  cnt_corr_b, cnt_unc_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] stub_err(input logic [7:0] lo);
    int n;
    n = $countones(lo);
    return (n >= 3) ? 2'd3 : 2'(n);
  endfunction

  assign dec_errors_a = stub_err(dec_codeword_a[7:0]);
  assign dec_data_a   = dec_codeword_a >> 8;
  assign dec_errors_b = stub_err(dec_codeword_b[7:0]);
  assign dec_data_b   = dec_codeword_b >> 8;

  ecc_decode_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_codeword(in_codeword), .in_width(in_width),
    .dec_codeword(dec_codeword_a), .dec_width(dec_width_a),
    .dec_data(dec_data_a), .dec_errors(dec_errors_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_errors(out_errors_a),
    .cnt_clear(cnt_clear), .cnt_corrected(cnt_corr_a),
    .cnt_uncorrectable(cnt_unc_a), .busy(busy_a)
  );

  ecc_decode_stage #(.DATA_WIDTH(16), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_codeword(in_codeword[15:0]), .in_width(in_width),
    .dec_codeword(dec_codeword_b), .dec_width(dec_width_b),
    .dec_data(dec_data_b), .dec_errors(dec_errors_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_errors(out_errors_b),
    .cnt_clear(cnt_clear), .cnt_corrected(cnt_corr_b),
    .cnt_uncorrectable(cnt_unc_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request in IDLE; returns at the negedge after acceptance (EVAL).
  task automatic send(input string tag, input logic [31:0] cw, input logic [1:0] w,
                      input logic [31:0] exp_cw_a, input logic [15:0] exp_cw_b);
    check({tag, "_in_ready_pre"}, 32'(in_ready_a & in_ready_b), 32'd1);
    in_codeword = cw;
    in_width    = w;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_dec_cw_a"}, dec_codeword_a, exp_cw_a);
    check({tag, "_dec_cw_b"}, 32'(dec_codeword_b), 32'(exp_cw_b));
    check({tag, "_dec_width"}, 32'(dec_width_a), 32'(w));
    check({tag, "_busy_ready"}, {30'd0, busy_a, in_ready_a}, 32'd2);
  endtask

  // One edge later the result must be held with out_valid high.
  task automatic expect_out(input string tag, input logic [31:0] da, input logic [1:0] ea,
                            input logic [15:0] db, input logic [1:0] eb);
    @(negedge clk);
    check({tag, "_vld"}, {30'd0, out_valid_a, out_valid_b}, 32'd3);
    check({tag, "_in_ready"}, 32'(in_ready_a | in_ready_b), 32'd0);
    check({tag, "_data_a"}, out_data_a, da);
    check({tag, "_err_a"}, 32'(out_errors_a), 32'(ea));
    check({tag, "_data_b"}, 32'(out_data_b), 32'(db));
    check({tag, "_err_b"}, 32'(out_errors_b), 32'(eb));
  endtask

  // With out_ready high the next edge completes the transfer.
  task automatic finish_xfer(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_vld"}, 32'(out_valid_a | out_valid_b), 32'd0);
    check({tag, "_done_ready"}, {30'd0, in_ready_a, in_ready_b}, 32'd3);
  endtask

  task automatic check_cnts(input string tag, input logic [15:0] ca, input logic [15:0] ua,
                            input logic [1:0] cb, input logic [1:0] ub);
    check({tag, "_cnt_a"}, {cnt_corr_a, cnt_unc_a}, {ca, ua});
    check({tag, "_cnt_b"}, 32'({cnt_corr_b, cnt_unc_b}), 32'({cb, ub}));
  endtask

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    cnt_clear   = 1'b0;
    in_codeword = 32'd0;
    in_width    = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_outs_a", {out_valid_a, busy_a, out_errors_a, out_data_a[27:0]}, 32'd0);
    check("rst_dec_a", dec_codeword_a, 32'd0);
    check_cnts("rst", 16'd0, 16'd0, 2'd0, 2'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {30'd0, in_ready_a, in_ready_b}, 32'd3);

    // Clean, corrected, double error with masking, wider and illegal widths.
    send("clean", 32'h0000_0000, 2'd0, 32'h0, 16'h0);
    expect_out("clean", 32'h0, 2'd0, 16'h0, 2'd0);
    finish_xfer("clean");
    check_cnts("clean", 16'd0, 16'd0, 2'd0, 2'd0);

    send("corr", 32'h0000_0001, 2'd0, 32'h1, 16'h1);
    expect_out("corr", 32'h0, 2'd1, 16'h0, 2'd1);
    finish_xfer("corr");
    check_cnts("corr", 16'd1, 16'd0, 2'd1, 2'd0);

    send("dbl", 32'hFFFF_FF03, 2'd0, 32'h0000_0003, 16'h0003);
    expect_out("dbl", 32'h0, 2'd2, 16'h0, 2'd2);
    finish_xfer("dbl");
    check_cnts("dbl", 16'd1, 16'd1, 2'd1, 2'd1);

    send("w16", 32'h1234_AB00, 2'd1, 32'h0000_AB00, 16'hAB00);
    expect_out("w16", 32'h0000_00AB, 2'd0, 16'h00AB, 2'd0);
    finish_xfer("w16");

    send("w32", 32'h5600_0001, 2'd2, 32'h5600_0001, 16'h0001);
    expect_out("w32", 32'h0056_0000, 2'd1, 16'h0, 2'd3);
    finish_xfer("w32");
    check_cnts("w32", 16'd2, 16'd1, 2'd1, 2'd1);

    send("wres", 32'h0000_0001, 2'd3, 32'h0000_0001, 16'h0001);
    expect_out("wres", 32'h0, 2'd3, 16'h0, 2'd3);
    finish_xfer("wres");
    check_cnts("wres", 16'd2, 16'd1, 2'd1, 2'd1);

    send("tri", 32'h0000_0007, 2'd0, 32'h7, 16'h7);
    expect_out("tri", 32'h0, 2'd2, 16'h0, 2'd2);
    finish_xfer("tri");
    check_cnts("tri", 16'd2, 16'd2, 2'd1, 2'd2);

    // Backpressure: result held for 10 cycles while a second request waits.
    out_ready = 1'b0;
    send("bp", 32'h0000_0001, 2'd0, 32'h1, 16'h1);
    expect_out("bp", 32'h0, 2'd1, 16'h0, 2'd1);
    check_cnts("bp", 16'd3, 16'd2, 2'd2, 2'd2);
    in_codeword = 32'h0000_0101;
    in_width    = 2'd1;
    in_valid    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_out", {out_valid_a, in_ready_a, out_errors_a, out_data_a[27:0]},
            {1'b1, 1'b0, 2'd1, 28'd0});
      check("bp_hold_dec", dec_codeword_a, 32'h1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {30'd0, in_ready_a, out_valid_a}, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp2_dec_a", dec_codeword_a, 32'h0000_0101);
    check("bp2_busy", 32'(busy_a & busy_b), 32'd1);
    expect_out("bp2", 32'h1, 2'd1, 16'h1, 2'd1);
    finish_xfer("bp2");
    check_cnts("bp2", 16'd4, 16'd2, 2'd3, 2'd2);

    // Saturation: two more single-error words keep the 2-bit counter at 3.
    for (int i = 0; i < 2; i++) begin
      send("sat", 32'h0000_0080, 2'd0, 32'h80, 16'h80);
      expect_out("sat", 32'h0, 2'd1, 16'h0, 2'd1);
      finish_xfer("sat");
    end
    check_cnts("sat", 16'd6, 16'd2, 2'd3, 2'd2);

    // Clear on the same edge as an increment: clear wins.
    send("clr", 32'h0000_0001, 2'd0, 32'h1, 16'h1);
    cnt_clear = 1'b1;
    expect_out("clr", 32'h0, 2'd1, 16'h0, 2'd1);
    cnt_clear = 1'b0;
    check_cnts("clr", 16'd0, 16'd0, 2'd0, 2'd0);
    finish_xfer("clr");

    // Reset while holding a result drops it.
    out_ready = 1'b0;
    send("rmid", 32'h0000_0003, 2'd0, 32'h3, 16'h3);
    expect_out("rmid", 32'h0, 2'd2, 16'h0, 2'd2);
    rst = 1'b0;
    @(negedge clk);
    check("rmid_outs_a", {out_valid_a, busy_a, out_errors_a, out_data_a[27:0]}, 32'd0);
    check("rmid_outs_b", {14'd0, out_valid_b, busy_b, out_data_b}, 32'd0);
    check("rmid_dec", {dec_codeword_a[29:0], dec_width_a}, 32'd0);
    check_cnts("rmid", 16'd0, 16'd0, 2'd0, 2'd0);
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rmid_after", {29'd0, in_ready_a, out_valid_a, busy_a}, 32'd4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ecc_decode_stage.md
# ecc_decode_stage

Registered, handshaked decode stage that feeds the combinational `decoder` and consumes its result. It accepts a noisy codeword and width code from the register/datapath side with a valid/ready handshake, then masks and holds the codeword on the decoder inputs. One cycle later it captures `Decoded_Data`/`NumOfErrors` into an output register with its own valid/ready handshake. It also keeps saturating counters of corrected and uncorrectable words for status readback.

## Interface
Parameters:
- `DATA_WIDTH`, 32: maximum codeword width. Legal values are 8, 16, 32; it must match the attached decoder.
- `CNT_WIDTH`, 16: width of each statistics counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage can accept a request.
- `in_codeword`  in  DATA_WIDTH  noisy codeword.
- `in_width`  in  2  width code: 0 = 8 bits, 1 = 16 bits, 2 = 32 bits, 3 = reserved.
- `dec_codeword`  out  DATA_WIDTH  registered, masked codeword driven to decoder `NoisyCodeWord`.
- `dec_width`  out  2  registered width driven to decoder `Codeword_Width`.
- `dec_data`  in  DATA_WIDTH  decoder `Decoded_Data`.
- `dec_errors`  in  2  decoder `NumOfErrors`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  DATA_WIDTH  registered decoded data.
- `out_errors`  out  2  0 = clean, 1 = corrected, 2 = uncorrectable, 3 = illegal width.
- `cnt_clear`  in  1  synchronous clear of both counters.
- `cnt_corrected`  out  CNT_WIDTH  count of words with `out_errors` = 1.
- `cnt_uncorrectable`  out  CNT_WIDTH  count of words with `out_errors` = 2.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
The FSM has three states: IDLE, EVAL, HOLD.

- **IDLE**: `in_ready` = 1.
  - When `in_valid` is high, capture the request:
    - `dec_width` <= `in_width`.
    - `dec_codeword` <= `in_codeword` with bits at or above the codeword length forced to 0 (length 8/16/32 for width code 0/1/2).
  - Go to EVAL.
- **EVAL**: `in_ready` = 0. The decoder settles combinationally on the held inputs.
  - Capture the result: `out_data` <= `dec_data`, `out_errors` <= `dec_errors`, `out_valid` <= 1.
  - Go to HOLD.
- **HOLD**: `out_valid` = 1; `out_data` and `out_errors` are stable.
  - When `out_ready` is high, clear `out_valid` and go to IDLE.
  - Otherwise stay in HOLD indefinitely.

Illegal width handling:
- A width is illegal when the code is 3, or when it selects a length greater than `DATA_WIDTH` (e.g. code 2 with `DATA_WIDTH` = 16).
- An illegal request is still accepted.
- At EVAL capture: `out_data` = 0, `out_errors` = 3, and counters are not incremented.

Decoder result 3 on a legal width is treated as uncorrectable: `out_errors` = 2.

Counters, updated on the EVAL capture edge:
- `out_errors` 1 increments `cnt_corrected`; 2 increments `cnt_uncorrectable`.
- Both counters saturate at all-ones and never wrap.
- `cnt_clear` wins over a same-cycle increment: the counter reads 0 afterwards and that increment is lost.

`dec_codeword` and `dec_width` hold their last values after EVAL; they are not re-zeroed.

Reset (`rst` = 0 sampled on an edge):
- State goes to IDLE.
- `out_valid`, `out_data`, `out_errors`, `dec_codeword`, `dec_width`, `cnt_corrected`, `cnt_uncorrectable` all go to 0.
- `busy` = 0 and `in_ready` = 1 once reset is released.
- Reset mid-operation (EVAL or HOLD) drops the pending word without producing a result or counting it.

## Timing
- Request accepted at edge k (IDLE, `in_valid` = 1).
- `dec_*` valid after edge k; result captured at edge k+1; `out_valid` high from edge k+1.
- Minimum latency is 2 edges from acceptance to `out_valid` visible; `out_data`/`out_errors` become valid in the same cycle as `out_valid`.
- Transfer out completes at the first edge with `out_valid` and `out_ready` both high.
- `in_ready` rises the cycle after that edge.
- Peak throughput is one word per 3 cycles when `out_ready` is held high.
- `in_ready` is a pure function of state. `in_ready` and `out_valid` are never high in the same cycle.
- `in_codeword`/`in_width` are don't-care while `in_ready` = 0.
- The decoder path has a full cycle from `dec_*` registers to `out_*` registers.

## Test plan
- **Clean and corrected**: width 0, codeword 8'h00, `out_ready` = 1 -> `out_valid` 2 edges after acceptance, `out_data` = 0, `out_errors` = 0, counters unchanged. Then 8'h01 -> `out_errors` = 1, `out_data` = 0, `cnt_corrected` = 1.
- **Double error and masking**: width 0, 32'hFFFF_FF03 -> `dec_codeword` = 32'h0000_0003, `out_errors` = 2, `cnt_uncorrectable` = 1.
- **Backpressure**: `out_ready` = 0 for 10 cycles after `out_valid` -> `out_data`/`out_errors` stable, `in_ready` = 0, a second request with `in_valid` held is not accepted until the cycle after `out_ready` = 1.
- **Illegal width**: width 3, and width 2 with `DATA_WIDTH` = 16 -> `out_errors` = 3, `out_data` = 0, counters unchanged.
- **Saturation and clear**: `CNT_WIDTH` = 2, five single-error words -> `cnt_corrected` = 3. Then `cnt_clear` on the same edge as a sixth increment -> 0.
- **Reset mid-operation**: `rst` = 0 during HOLD -> next edge: `out_valid` = 0, all outputs 0, `in_ready` = 1 after release, no result emitted for the dropped word.
